seg_display_mux: RTL and testbench
==================================

Name: seg_display_mux

Overview:
Parametrised multiplexed seven-segment display controller for the board's debug/LED output path. Captures a value on a load strobe and formats it as hex, unsigned decimal or signed decimal. Decimal conversion uses a sequential shift-add-3 (double-dabble) engine instead of combinational dividers. The controller then time-multiplexes DIGITS glyphs onto one shared segment bus, with leading-zero blanking, per-digit decimal points and an error display.

Parameters:
DIGITS, 4, number of digit positions; legal range 3..8.
WIDTH, 32, width of the input value in bits; legal range 8..32.
REFRESH_DIV, 10000, clk cycles per digit slot; must be ≥2.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
value  input  WIDTH  value to display; sampled on load
mode  input  2  00 hex, 01 unsigned decimal, 10 signed decimal, 11 blank; sampled on load
load  input  1  capture strobe; honoured only when busy=0
blank_lz  input  1  1 = blank leading zeros; sampled on load
dp_mask  input  DIGITS  decimal point enable per digit; live, not sampled
busy  output  1  decimal conversion in progress
err  output  1  last loaded value did not fit; sticky until next accepted load
digit_out  output  8  [7:1] segments a..g (a = bit 7), [0] dp; active-high
cs_out  output  DIGITS  digit select, active-low one-hot; bit 0 = rightmost digit

Behaviour:
- Reset (rst=0, asynchronous): scan index=0, refresh counter=0, all glyph registers=blank (0000000), busy=0, err=0. Therefore digit_out=8'h00 and cs_out=~1 (only bit 0 low).
- Reset asserted mid-conversion aborts the conversion. The display stays blank until a new load.
- Glyphs: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111 r=0000101 '-'=0000001 blank=0000000.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and the scan index advances 0→1→…→DIGITS-1→0.
- cs_out = ~(1<<scan index).
- digit_out[7:1] = glyph[scan index]. digit_out[0] = dp_mask[scan index] & ~err.
- Scan runs continuously and independently of load/busy.
- load when busy=1: ignored. value, mode, err and display are unchanged.
- Hex (mode 00): nibble i of value is displayed in digit i.
  - Glyph registers update on the edge after the load edge; busy is never asserted.
  - Bits above 4*DIGITS are truncated; err=0.
  - blank_lz=1 blanks zero nibbles above the most significant nonzero nibble. Digit 0 is always shown.
- Blank (mode 11): all glyphs blank on the next edge; err=0.
- Decimal (modes 01/10):
  - On load edge E0, latch the magnitude and set busy=1. The magnitude is value, or for mode 10 with value[WIDTH-1]=1, the WIDTH-bit unsigned two's complement (~value+1); 2^(WIDTH-1) is represented exactly.
  - Edges E1..E_WIDTH each perform one double-dabble step into a 4*DIGITS-bit BCD register: add 3 to every BCD digit ≥5, then shift in the magnitude MSB.
  - Edge E_WIDTH+1 formats, writes all glyph registers atomically, and clears busy. busy is therefore high for exactly WIDTH+1 cycles.
  - A BCD carry-out past digit DIGITS-1 at any step marks overflow.
- Decimal format:
  - Unsigned: BCD digit i is displayed in digit i, with blank_lz as in hex.
  - Signed negative, blank_lz=1: '-' goes immediately left of the most significant nonzero digit.
  - Signed negative, blank_lz=0: '-' goes in digit DIGITS-1.
  - A negative magnitude needing more than DIGITS-1 digits is an overflow.
- Overflow: err=1; display reads "Err" right-aligned (digit0=r, digit1=r, digit2=E, higher digits blank); dp suppressed.
- Glyph registers never hold partially converted data. The previous display is held until the formatting edge.
- mode, value and blank_lz changes without an accepted load have no effect.

Test Plan:
(DIGITS=4, WIDTH=32, REFRESH_DIV=4 in sim)
1. Reset, release, run 20 cycles → digit_out=00 while blank; cs_out sequence 1110,1101,1011,0111,1110 changing every 4 clk.
2. load value=32'h00001A2F, mode=00, blank_lz=0 → busy stays 0. One edge later digits 0..3 = F(1000111), 2(1101101), A(1110111), 1(0110000). dp_mask=4'b0100 lights dp only in slot 2.
3. load 1234, mode=01 → busy high exactly 33 cycles; then digits 0..3 = 4,3,2,1, err=0. Then load 7 with blank_lz=1 → digit0=7, digits1..3 = 0000000.
4. load 32'hFFFFFFFB (−5), mode=10, blank_lz=1 → digit0=5, digit1='-' (0000001), digits2..3 blank. Same value with blank_lz=0 → digits 5,0,0,'-'.
5. Overflow, mode=01 value 10000 and mode=10 value 32'h80000000 → each gives err=1, display "Err" (0000101, 0000101, 1001111, blank), digit_out[0]=0 with dp_mask=4'b1111.
6. load 9999 mode=01, then pulse load with 42 during busy → display 9,9,9,9 and the second load ignored. Assert rst low at cycle 10 of a new conversion → immediate blank display, busy=0, err=0.

Source files
------------

// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux
//
// Multiplexed seven-segment display controller. A value captured on a load
// strobe is shown as hex, unsigned decimal or signed decimal. Decimal values
// are converted by a sequential shift-add-3 (double-dabble) engine, one bit
// per clock. The DIGITS glyphs are then time-multiplexed onto one shared
// segment bus. Leading-zero blanking, per-digit decimal points and an "Err"
// overflow display are supported.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   value      value to display, sampled on an accepted load
//   mode       00 hex, 01 unsigned dec, 10 signed dec, 11 blank (sampled)
//   load       capture strobe, accepted only while busy=0
//   blank_lz   1 = blank leading zeros (sampled on load)
//   dp_mask    live per-digit decimal point enables
//   busy       decimal conversion in progress
//   err        last loaded value did not fit the display
//   digit_out  [7:1] segments a..g (a = bit 7), [0] decimal point, active-high
//   cs_out     active-low one-hot digit select, bit 0 = rightmost digit
// -----------------------------------------------------------------------------
module seg_display_mux #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 32,
    parameter int REFRESH_DIV = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              err,
    output logic [7:0]        digit_out,
    output logic [DIGITS-1:0] cs_out
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SCAN_W = $clog2(DIGITS);
    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SEG_W  = 7 * DIGITS;

    localparam logic [1:0] MODE_HEX   = 2'b00;
    localparam logic [1:0] MODE_UDEC  = 2'b01;
    localparam logic [1:0] MODE_SDEC  = 2'b10;
    localparam logic [1:0] MODE_BLANK = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_R     = 7'b0000101;
    localparam logic [6:0] SEG_E     = 7'b1001111;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Scan state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SCAN_W-1:0] scan_q, scan_d;

    // Display state
    logic [SEG_W-1:0]  glyph_q, glyph_d;
    logic              err_q, err_d;

    // Capture / conversion state
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;      // hex/blank format pending next edge
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        fmt_mode_q, fmt_mode_d;
    logic              blank_lz_q, blank_lz_d;
    logic              neg_q, neg_d;

    // Combinational helpers
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  hex_src;
    logic [BCD_W-1:0]  src;
    logic [SCAN_W-1:0] msd;
    logic              fmt_err;
    logic [SEG_W-1:0]  fmt_seg;
    logic [WIDTH-1:0]  mag_in;

    // Double-dabble adjust: every BCD digit >= 5 gets +3 before the shift.
    // A digit never exceeds 9 while the value fits, so +3 stays within 4 bits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                  ? bcd_q[4*gi +: 4] + 4'd3
                                  : bcd_q[4*gi +: 4];
    end

    // Hex source: low 4*DIGITS bits of the captured value, zero-extended
    // when the value is narrower than the display.
    for (genvar gi = 0; gi < BCD_W; gi++) begin : g_hex
        if (gi < WIDTH) begin : g_bit
            assign hex_src[gi] = mag_q[gi];
        end else begin : g_zero
            assign hex_src[gi] = 1'b0;
        end
    end

    assign src = (fmt_mode_q == MODE_HEX) ? hex_src : bcd_q;

    // Most significant nonzero digit (0 when everything is zero, so digit 0
    // is always shown under leading-zero blanking).
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (src[4*i +: 4] != 4'd0) begin
                msd = SCAN_W'(i);
            end
        end
    end

    // A negative number needs one extra position for the minus sign.
    assign fmt_err = ((fmt_mode_q == MODE_UDEC) || (fmt_mode_q == MODE_SDEC))
                   && (ovf_q || (neg_q && (msd == SCAN_W'(DIGITS - 1))));

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_fmt
        localparam logic [6:0] ERR_SEG = (gi < 2) ? SEG_R :
                                         (gi == 2) ? SEG_E : SEG_BLANK;
        assign fmt_seg[7*gi +: 7] =
            (fmt_mode_q == MODE_BLANK)                        ? SEG_BLANK :
            fmt_err                                           ? ERR_SEG   :
            (neg_q && blank_lz_q && (int'(msd) + 1 == gi))    ? SEG_MINUS :
            (neg_q && !blank_lz_q && (gi == DIGITS - 1))      ? SEG_MINUS :
            (blank_lz_q && (int'(msd) < gi))                  ? SEG_BLANK :
                                                                seg_of(src[4*gi +: 4]);
    end

    // Signed magnitude; 2^(WIDTH-1) negates to itself and reads back exactly
    // when taken as unsigned.
    assign mag_in = ((mode == MODE_SDEC) && value[WIDTH-1])
                  ? (~value + WIDTH'(1)) : value;

    always_comb begin
        // Continuous scan
        cnt_d  = cnt_q + CNT_W'(1);
        scan_d = scan_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d  = '0;
            scan_d = (scan_q == SCAN_W'(DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
        end

        glyph_d    = glyph_q;
        err_d      = err_q;
        busy_d     = busy_q;
        pend_d     = 1'b0;
        step_d     = step_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        fmt_mode_d = fmt_mode_q;
        blank_lz_d = blank_lz_q;
        neg_d      = neg_q;

        if (busy_q) begin
            if (step_q != STEP_W'(WIDTH)) begin
                bcd_d  = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
                ovf_d  = ovf_q | bcd_adj[BCD_W-1];
                mag_d  = mag_q << 1;
                step_d = step_q + STEP_W'(1);
            end else begin
                // err moves with the glyphs so the dp suppression always
                // matches the text on the display.
                glyph_d = fmt_seg;
                err_d   = fmt_err;
                busy_d  = 1'b0;
            end
        end

        if (pend_q) begin
            glyph_d = fmt_seg;
            err_d   = fmt_err;
        end

        if (load && !busy_q) begin
            fmt_mode_d = mode;
            blank_lz_d = blank_lz;
            if ((mode == MODE_UDEC) || (mode == MODE_SDEC)) begin
                neg_d  = (mode == MODE_SDEC) && value[WIDTH-1];
                mag_d  = mag_in;
                bcd_d  = '0;
                ovf_d  = 1'b0;
                step_d = '0;
                busy_d = 1'b1;
            end else begin
                neg_d  = 1'b0;
                mag_d  = value;
                ovf_d  = 1'b0;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            scan_q     <= '0;
            glyph_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            step_q     <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            fmt_mode_q <= MODE_BLANK;
            blank_lz_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            glyph_q    <= glyph_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            step_q     <= step_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            fmt_mode_q <= fmt_mode_d;
            blank_lz_q <= blank_lz_d;
            neg_q      <= neg_d;
        end
    end

    assign busy      = busy_q;
    assign err       = err_q;
    assign cs_out    = ~(DIGITS'(1) << scan_q);
    assign digit_out = {glyph_q[7*scan_q +: 7], dp_mask[scan_q] & ~err_q};

endmodule

// File: tb/tb_seg_display_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_display_mux
//
// Directed self-checking bench for seg_display_mux with DIGITS=4, WIDTH=32,
// REFRESH_DIV=4. Each scenario task drives stimulus on the falling edge and
// compares outputs on the falling edge against hand-computed segment codes.
// -----------------------------------------------------------------------------
module tb_seg_display_mux;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 32;
    localparam int RDIV   = 4;

    // Expected digit_out codes {segments a..g, dp=0}
    localparam logic [7:0] D_0 = 8'hFC;
    localparam logic [7:0] D_1 = 8'h60;
    localparam logic [7:0] D_2 = 8'hDA;
    localparam logic [7:0] D_3 = 8'hF2;
    localparam logic [7:0] D_4 = 8'h66;
    localparam logic [7:0] D_5 = 8'hB6;
    localparam logic [7:0] D_7 = 8'hE0;
    localparam logic [7:0] D_9 = 8'hF6;
    localparam logic [7:0] D_A = 8'hEE;
    localparam logic [7:0] D_F = 8'h8E;
    localparam logic [7:0] D_E = 8'h9E;
    localparam logic [7:0] D_R = 8'h0A;
    localparam logic [7:0] D_M = 8'h02;
    localparam logic [7:0] D_B = 8'h00;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  value;
    logic [1:0]        mode;
    logic              load;
    logic              blank_lz;
    logic [DIGITS-1:0] dp_mask;
    logic              busy;
    logic              err;
    logic [7:0]        digit_out;
    logic [DIGITS-1:0] cs_out;

    int tests_run;
    int tests_failed;

    seg_display_mux #(
        .DIGITS      (DIGITS),
        .WIDTH       (WIDTH),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .mode      (mode),
        .load      (load),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .busy      (busy),
        .err       (err),
        .digit_out (digit_out),
        .cs_out    (cs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for the scan to reach a digit; returns 'z on timeout so
    // the caller's comparison fails.
    task automatic read_digit(input int idx, output logic [7:0] d);
        logic [DIGITS-1:0] one;
        one = 4'b0001;
        d = 8'hzz;
        for (int k = 0; k < 4 * DIGITS * RDIV + 4; k++) begin
            if (cs_out === ~(one << idx)) begin
                d = digit_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic [1:0] m,
                           input logic blz);
        value    = v;
        mode     = m;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        logic [DIGITS-1:0] exp_cs;
        logic [DIGITS-1:0] one;
        one = 4'b0001;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_out !== 8'h00 || cs_out !== 4'b1110 || busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: digit_out=%h cs_out=%b busy=%b err=%b, want 00 1110 0 0",
                     digit_out, cs_out, busy, err);
        end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_cs = ~(one << ((k / RDIV) % DIGITS));
            tests_run++;
            if (cs_out !== exp_cs || digit_out !== 8'h00) begin
                tests_failed++;
                $display("FAIL scan_k%0d: cs_out=%b digit_out=%h, want %b 00",
                         k, cs_out, digit_out, exp_cs);
            end
            $display("[TB] scan cycle %0d cs_out=%b", k, cs_out);
            @(negedge clk);
        end
    endtask

    task automatic test_hex;
        logic [7:0] d;
        logic [7:0] exp_d [DIGITS];
        dp_mask = 4'b0000;
        do_load(32'h00001A2F, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL hex_busy_%0d: busy=%b, want 0", k, busy);
            end
            @(negedge clk);
        end
        exp_d = '{D_F, D_2, D_A, D_1};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL hex_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
            $display("[TB] hex 1A2F digit %0d = %h", i, d);
        end
        dp_mask = 4'b0100;
        exp_d = '{D_F, D_2, D_A | 8'h01, D_1};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL hex_dp_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_udec;
        logic [7:0] d;
        logic [7:0] exp_d [DIGITS];
        int busy_cycles;
        bit ok;
        do_load(32'd1234, 2'b01, 1'b0);
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        tests_run++;
        if (busy_cycles != WIDTH + 1) begin
            tests_failed++;
            $display("FAIL udec_busy_len: busy for %0d cycles, want %0d", busy_cycles, WIDTH + 1);
        end
        $display("[TB] load 1234 dec: busy %0d cycles", busy_cycles);
        exp_d = '{D_4, D_3, D_2, D_1};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL udec1234_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL udec1234_err: err=%b, want 0", err);
        end

        do_load(32'd7, 2'b01, 1'b1);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL udec7_idle: busy stuck at %b, want 0", busy);
        end
        exp_d = '{D_7, D_B, D_B, D_B};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL udec7_lz_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
        end
        $display("[TB] load 7 dec blank_lz: digit0=%h", exp_d[0]);
    endtask

    task automatic test_sdec;
        logic [7:0] d;
        logic [7:0] exp_d [DIGITS];
        bit ok;
        do_load(32'hFFFFFFFB, 2'b10, 1'b1);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL sdec_idle_lz: busy stuck at %b, want 0", busy);
        end
        exp_d = '{D_5, D_M, D_B, D_B};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL sdec_neg5_lz_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
        end
        $display("[TB] load -5 signed blank_lz=1 done");

        do_load(32'hFFFFFFFB, 2'b10, 1'b0);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL sdec_idle_nolz: busy stuck at %b, want 0", busy);
        end
        exp_d = '{D_5, D_0, D_0, D_M};
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL sdec_neg5_digit%0d: got %h, want %h", i, d, exp_d[i]);
            end
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sdec_err: err=%b, want 0", err);
        end
        $display("[TB] load -5 signed blank_lz=0 done");
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        logic [7:0] exp_d [DIGITS];
        logic [WIDTH-1:0] vals [2];
        logic [1:0] modes [2];
        bit ok;
        vals  = '{32'd10000, 32'h80000000};
        modes = '{2'b01, 2'b10};
        dp_mask = 4'b1111;
        exp_d = '{D_R, D_R, D_E, D_B};
        for (int t = 0; t < 2; t++) begin
            do_load(vals[t], modes[t], 1'b0);
            wait_idle(ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL ovf%0d_idle: busy stuck at %b, want 0", t, busy);
            end
            tests_run++;
            if (err !== 1'b1) begin
                tests_failed++;
                $display("FAIL ovf%0d_err: err=%b, want 1", t, err);
            end
            for (int i = 0; i < DIGITS; i++) begin
                read_digit(i, d);
                tests_run++;
                if (d !== exp_d[i]) begin
                    tests_failed++;
                    $display("FAIL ovf%0d_digit%0d: got %h, want %h", t, i, d, exp_d[i]);
                end
            end
            $display("[TB] overflow load %h mode %b err=%b", vals[t], modes[t], err);
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        bit ok;
        do_load(32'd9999, 2'b01, 1'b0);
        // Previous "Err" text must stay until the formatting edge.
        read_digit(2, d);
        tests_run++;
        if (d !== D_E) begin
            tests_failed++;
            $display("FAIL hold_during_busy: got %h, want %h", d, D_E);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_before_pulse: busy=%b, want 1", busy);
        end
        do_load(32'd42, 2'b00, 1'b0);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy stuck at %b, want 0", busy);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== D_9) begin
                tests_failed++;
                $display("FAIL b2b_digit%0d: got %h, want %h", i, d, D_9);
            end
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_err: err=%b, want 0", err);
        end
        $display("[TB] load 9999 with ignored load 42 done");
    endtask

    task automatic test_reset_mid_conversion;
        logic [7:0] d;
        do_load(32'd1234, 2'b01, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0 || digit_out !== 8'h00 || cs_out !== 4'b1110) begin
            tests_failed++;
            $display("FAIL mid_reset: busy=%b err=%b digit_out=%h cs_out=%b, want 0 0 00 1110",
                     busy, err, digit_out, cs_out);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_busy: busy=%b, want 0", busy);
        end
        for (int i = 0; i < DIGITS; i++) begin
            read_digit(i, d);
            tests_run++;
            if (d !== D_B) begin
                tests_failed++;
                $display("FAIL post_reset_digit%0d: got %h, want %h", i, d, D_B);
            end
        end
        $display("[TB] reset during conversion done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        value    = '0;
        mode     = 2'b00;
        load     = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        @(negedge clk);
        test_reset;
        test_hex;
        test_udec;
        test_sdec;
        test_overflow;
        test_back_to_back;
        test_reset_mid_conversion;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
